// File: rtl/mips_regfile_sb.sv
// ============================================================================
// mips_regfile_sb : parametrised MIPS register file, registered read ports,
//                   write-first bypass and per-register busy scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_RD-1:0]          RdEn,
  input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
  output logic [NUM_RD*DATA_W-1:0]   RdData,
  output logic [NUM_RD-1:0]          RdBusy,
  input  logic                       WrEn,
  input  logic [ADDR_W-1:0]          WrAddr,
  input  logic [DATA_W-1:0]          WrData,
  input  logic                       IssueEn,
  input  logic [ADDR_W-1:0]          IssueAddr,
  output logic                       IssueAccept,
  output logic [2**ADDR_W-1:0]       BusyVec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic                     w_wr_live;
  logic                     w_iss_set;

  // Writes and issues aimed at a hardwired r0 are swallowed here.
  assign w_wr_live   = WrEn && !((ZERO_REG != 0) && (WrAddr == '0));
  assign IssueAccept = IssueEn && (!busy_q[IssueAddr] || (WrEn && (WrAddr == IssueAddr)));
  assign w_iss_set   = IssueAccept && !((ZERO_REG != 0) && (IssueAddr == '0));

  // Issue is applied after the write-back clear so the new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (w_wr_live) busy_d[WrAddr] = 1'b0;
    if (w_iss_set) busy_d[IssueAddr] = 1'b1;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int k = 0; k < NUM_RD; k++) begin
      if (RdEn[k]) begin
        if ((ZERO_REG != 0) && (RdAddr[k*ADDR_W +: ADDR_W] == '0))
          rd_data_d[k*DATA_W +: DATA_W] = '0;
        else if (WrEn && (WrAddr == RdAddr[k*ADDR_W +: ADDR_W]))
          rd_data_d[k*DATA_W +: DATA_W] = WrData;
        else
          rd_data_d[k*DATA_W +: DATA_W] = regs_q[RdAddr[k*ADDR_W +: ADDR_W]];
        rd_busy_d[k] = busy_d[RdAddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      if (w_wr_live) regs_q[WrAddr] <= WrData;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign RdData  = rd_data_q;
  assign RdBusy  = rd_busy_q;
  assign BusyVec = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
// ============================================================================
// tb_mips_regfile_sb : directed table vectors plus randomized traffic checked
//                      against an array-based register/scoreboard model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_regfile_sb;

  typedef struct {
    bit          rst;
    bit          wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          ien;
    logic [4:0]  ia;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    bit          e_acc;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rb;
    logic [31:0] e_bv;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [1:0]  RdEn = '0;
  logic [9:0]  RdAddr = '0;
  logic [63:0] RdData;
  logic [1:0]  RdBusy;
  logic        WrEn = 1'b0;
  logic [4:0]  WrAddr = '0;
  logic [31:0] WrData = '0;
  logic        IssueEn = 1'b0;
  logic [4:0]  IssueAddr = '0;
  logic        IssueAccept;
  logic [31:0] BusyVec;

  int n_vec = 0;
  int n_miss = 0;

  // Reference state: register contents, busy flags, last read results.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  logic [31:0] m_rd   [2];
  bit          m_rb   [2];
  bit          m_acc;

  always #5 CLK = ~CLK;

  mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .CLK(CLK), .RESET(RESET), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
    .RdBusy(RdBusy), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .IssueAccept(IssueAccept),
    .BusyVec(BusyVec)
  );

  function automatic vec_t mk(bit rst, bit wen, logic [4:0] wa, logic [31:0] wd,
                              bit ien, logic [4:0] ia, logic [1:0] ren,
                              logic [4:0] ra0, logic [4:0] ra1, bit e_acc,
                              logic [31:0] e_rd0, logic [31:0] e_rd1,
                              logic [1:0] e_rb, logic [31:0] e_bv);
    vec_t v;
    v.rst = rst; v.wen = wen; v.wa = wa; v.wd = wd; v.ien = ien; v.ia = ia;
    v.ren = ren; v.ra0 = ra0; v.ra1 = ra1; v.e_acc = e_acc;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb = e_rb; v.e_bv = e_bv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_bv();
    logic [31:0] bv;
    for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
    return bv;
  endfunction

  task automatic model_edge(input vec_t v);
    logic [4:0] ra [2];
    ra[0] = v.ra0;
    ra[1] = v.ra1;
    if (v.rst) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      m_rd[0] = '0; m_rd[1] = '0; m_rb[0] = 0; m_rb[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (v.ren[k])
          m_rd[k] = (ra[k] == 0) ? 32'h0 : (v.wen && v.wa == ra[k]) ? v.wd : m_mem[ra[k]];
      if (v.wen && v.wa != 0) begin m_mem[v.wa] = v.wd; m_busy[v.wa] = 0; end
      if (m_acc && v.ia != 0) m_busy[v.ia] = 1;
      for (int k = 0; k < 2; k++)
        if (v.ren[k]) m_rb[k] = m_busy[ra[k]];
    end
  endtask

  // One clock: drive, check combinational accept, clock, check registered state.
  task automatic step(input vec_t v, input bit use_tab, input string tag);
    RESET = v.rst; WrEn = v.wen; WrAddr = v.wa; WrData = v.wd;
    IssueEn = v.ien; IssueAddr = v.ia; RdEn = v.ren; RdAddr = {v.ra1, v.ra0};
    #1;
    m_acc = v.ien && (!m_busy[v.ia] || (v.wen && v.wa == v.ia));
    chk({tag, ".IssueAccept"}, {31'b0, IssueAccept}, use_tab ? {31'b0, v.e_acc} : {31'b0, m_acc});
    model_edge(v);
    @(posedge CLK);
    #1;
    n_vec++;
    if (use_tab) begin
      chk({tag, ".RdData0"}, RdData[31:0],  v.e_rd0);
      chk({tag, ".RdData1"}, RdData[63:32], v.e_rd1);
      chk({tag, ".RdBusy"},  {30'b0, RdBusy}, {30'b0, v.e_rb});
      chk({tag, ".BusyVec"}, BusyVec, v.e_bv);
    end else begin
      chk({tag, ".RdData0"}, RdData[31:0],  m_rd[0]);
      chk({tag, ".RdData1"}, RdData[63:32], m_rd[1]);
      chk({tag, ".RdBusy"},  {30'b0, RdBusy}, {30'b0, m_rb[1], m_rb[0]});
      chk({tag, ".BusyVec"}, BusyVec, model_bv());
    end
  endtask

  vec_t tab [13];
  vec_t rv;

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    m_rd[0] = '0; m_rd[1] = '0; m_rb[0] = 0; m_rb[1] = 0; m_acc = 0;

    //           rst wen wa  wd            ien ia  ren    ra0 ra1 acc rd0           rd1           rb     bv
    tab[0]  = mk(1, 0, 0,  32'h0,        0, 0,  2'b00, 0,  0,  0, 32'h0,        32'h0,        2'b00, 32'h0);
    tab[1]  = mk(0, 0, 0,  32'h0,        0, 0,  2'b11, 5,  31, 0, 32'h0,        32'h0,        2'b00, 32'h0);
    tab[2]  = mk(0, 1, 3,  32'hDEADBEEF, 0, 0,  2'b00, 0,  0,  0, 32'h0,        32'h0,        2'b00, 32'h0);
    tab[3]  = mk(0, 0, 0,  32'h0,        0, 0,  2'b01, 3,  0,  0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0);
    tab[4]  = mk(0, 1, 0,  32'h1234,     0, 0,  2'b00, 0,  0,  0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0);
    tab[5]  = mk(0, 0, 0,  32'h0,        0, 0,  2'b01, 0,  0,  0, 32'h0,        32'h0,        2'b00, 32'h0);
    tab[6]  = mk(0, 1, 7,  32'hA5A5A5A5, 0, 0,  2'b11, 7,  7,  0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0);
    tab[7]  = mk(0, 0, 0,  32'h0,        1, 9,  2'b00, 0,  0,  1, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h200);
    tab[8]  = mk(0, 0, 0,  32'h0,        1, 9,  2'b00, 0,  0,  0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h200);
    tab[9]  = mk(0, 1, 9,  32'h55,       1, 9,  2'b01, 9,  0,  1, 32'h55,       32'hA5A5A5A5, 2'b01, 32'h200);
    tab[10] = mk(0, 0, 0,  32'h0,        1, 12, 2'b00, 0,  0,  1, 32'h55,       32'hA5A5A5A5, 2'b01, 32'h1200);
    tab[11] = mk(0, 1, 12, 32'hCAFE0012, 0, 0,  2'b11, 12, 9,  0, 32'hCAFE0012, 32'h55,       2'b10, 32'h200);
    tab[12] = mk(0, 0, 0,  32'h0,        1, 0,  2'b01, 0,  0,  1, 32'h0,        32'h55,       2'b10, 32'h200);

    @(posedge CLK);
    #1;
    for (int i = 0; i < 13; i++) step(tab[i], 1'b1, $sformatf("tab%0d", i));

    // Mid-operation reset: busy r1/r2 and r4=7 are lost, a write to r6 in the reset cycle is ignored.
    step(mk(0, 0, 0, 32'h0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rst_a");
    step(mk(0, 0, 0, 32'h0, 1, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rst_b");
    step(mk(0, 1, 4, 32'h7, 0, 0, 2'b11, 4, 2, 0, 0, 0, 0, 0), 1'b0, "rst_c");
    chk("rst_c.BusyVec_hand", BusyVec, 32'h206);
    step(mk(1, 1, 6, 32'h66, 1, 3, 2'b11, 4, 6, 1, 32'h0, 32'h0, 2'b00, 32'h0), 1'b1, "rst_d");
    step(mk(0, 0, 0, 32'h0,  0, 0, 2'b11, 4, 6, 0, 32'h0, 32'h0, 2'b00, 32'h0), 1'b1, "rst_e");

    // Random traffic over a narrow address window so hazards and bypasses are frequent.
    for (int n = 0; n < 600; n++) begin
      rv = mk($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              0, 0, 0, 0, 0);
      if ($urandom_range(0, 9) == 0) rv.wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rv.ra1 = 5'($urandom_range(0, 31));
      step(rv, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
Parametrised MIPS general-purpose register file with a per-register busy scoreboard. It replaces the fixed 32x32, two-read, no-write register bank.
- Provides NUM_RD registered read ports and one write-back port with write-first bypass.
- Register 0 is optionally hardwired to zero.
- Busy bits track in-flight destination registers so the decode/issue stage can detect RAW hazards.
- Sits between the instruction register (supplies read and destination addresses) and the ALU/write-back stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never goes busy

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
RdEn  input  NUM_RD  per-port read enable
RdAddr  input  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
RdData  output  NUM_RD*DATA_W  registered read data; port k = bits [k*DATA_W +: DATA_W]
RdBusy  output  NUM_RD  registered busy flag of the address read on port k
WrEn  input  1  write-back enable
WrAddr  input  ADDR_W  write-back address
WrData  input  DATA_W  write-back data
IssueEn  input  1  request to mark destination IssueAddr busy
IssueAddr  input  ADDR_W  destination register of the issuing instruction
IssueAccept  output  1  combinational; issue request granted this cycle
BusyVec  output  2**ADDR_W  registered busy bit per register

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high, sampled on posedge CLK, and overrides all other inputs in that cycle.
- Reset values: all registers 0, RdData 0, RdBusy 0, BusyVec 0. IssueAccept follows its equation using the cleared state.
- Write:
  - When WrEn=1 at posedge, REGS[WrAddr] <= WrData and busy[WrAddr] <= 0.
  - With ZERO_REG=1 and WrAddr=0, the write is dropped; busy[0] stays 0.
- Read:
  - Latency is 1 cycle. If RdEn[k]=1 at posedge N, RdData[k] is valid after posedge N and holds until the next enabled read on that port.
  - If RdEn[k]=0, RdData[k] and RdBusy[k] hold their values.
  - Bypass: if WrEn=1 and WrAddr==RdAddr[k] in the same cycle, RdData[k] <= WrData (write-first).
  - With ZERO_REG=1 and RdAddr[k]=0, RdData[k] <= 0 regardless of bypass.
  - Several ports may read the same address in the same cycle; each returns identical data.
- Scoreboard:
  - IssueAccept = IssueEn && (!busy[IssueAddr] || (WrEn && WrAddr==IssueAddr)). A write-back that frees the register in the same cycle allows the issue.
  - If IssueAccept=1, busy[IssueAddr] <= 1 at posedge, except when ZERO_REG=1 and IssueAddr=0: accepted, but the busy bit is not set.
  - A request that is not accepted (busy register) has no effect; the requester must hold and retry.
  - Write and accepted issue to the same address in one cycle: data is written, and busy ends at 1 (the new producer wins).
  - Write and issue to different addresses: both take effect independently.
- RdBusy[k] <= busy value of RdAddr[k] after this edge's update, including a same-cycle write clear or issue set.
- BusyVec reflects the busy state after each edge.
- Arithmetic: none. Address compares are full ADDR_W bits. No wrap or truncation; all addresses are in range by construction.
- Reset mid-operation: pending busy bits and stored data are lost. A write or issue in the reset cycle is ignored.

Test Plan:
1. Reset then read: assert RESET one cycle; read r5 and r31 on ports 0/1 -> RdData=0/0, RdBusy=0/0, BusyVec=0.
2. Write/readback: write r3=0xDEADBEEF at cycle N; read r3 at N+1 -> RdData[0]=0xDEADBEEF one cycle later. Write r0=0x1234 (ZERO_REG=1), read r0 -> 0.
3. Bypass: same cycle WrEn r7=0xA5A5A5A5 and RdEn r7 on both ports -> both RdData=0xA5A5A5A5 after that edge.
4. Hazard: issue r9 -> IssueAccept=1, BusyVec[9]=1. Next cycle issue r9 again -> IssueAccept=0. Then write r9=0x55 plus issue r9 in the same cycle -> IssueAccept=1, REGS[9]=0x55, BusyVec[9] stays 1.
5. Clear and RdBusy: issue r12; then write r12 and read r12 in the same cycle -> RdBusy[0]=0, RdData=written value, BusyVec[12]=0.
6. Mid-operation reset: set busy r1,r2 and write r4=7; assert RESET while also asserting WrEn r6 -> all registers 0, BusyVec=0, r6 reads 0.
